reg_dump_uart: RTL

REG_DUMP_UART -- requirements
Module: reg_dump_uart

---
 rtl/reg_dump_uart_pkg.sv | 16 +
 rtl/reg_dump_uart_tx.sv | 53 +++++
 rtl/reg_dump_uart.sv | 113 +++++++++++
 3 files changed

// File: rtl/reg_dump_uart_pkg.sv
// rtl/reg_dump_uart_pkg.sv - shared FSM encoding and constants for the register dump UART
package reg_dump_uart_pkg;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_HDR   = 3'd1,
        S_LATCH = 3'd2,
        S_BYTE  = 3'd3,
        S_NEXT  = 3'd4,
        S_DONE  = 3'd5
    } state_t;

    localparam logic [7:0] HDR_BYTE_DEFAULT = 8'hA5;
    localparam int         REG_COUNT        = 32;

endpackage

// File: rtl/reg_dump_uart_tx.sv
// rtl/reg_dump_uart_tx.sv - 8N1 LSB-first UART transmitter, tx_done high in the last stop-bit cycle
module uart_tx #(
    parameter int CLKS_PER_BIT = 868
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       tx_start,
    input  logic [7:0] tx_data,
    output logic       tx,
    output logic       tx_busy,
    output logic       tx_done
);
    localparam logic [15:0] LAST = 16'(CLKS_PER_BIT - 1);

    logic [15:0] cnt;
    logic [3:0]  bit_idx;
    logic [7:0]  data;

    // Done fires during the final stop-bit cycle so the caller can queue the next byte with one idle cycle.
    assign tx_done = tx_busy && (bit_idx == 4'd9) && (cnt == LAST);

    always_ff @(posedge clk) begin
        if (reset) begin
            tx      <= 1'b1;
            tx_busy <= 1'b0;
            cnt     <= '0;
            bit_idx <= '0;
            data    <= '0;
        end else if (!tx_busy) begin
            if (tx_start) begin
                tx_busy <= 1'b1;
                tx      <= 1'b0;
                data    <= tx_data;
                cnt     <= '0;
                bit_idx <= '0;
            end
        end else if (cnt == LAST) begin
            cnt <= '0;
            if (bit_idx == 4'd9) begin
                tx_busy <= 1'b0;
                tx      <= 1'b1;
            end else begin
                // Shifting ones in from the top makes the ninth output the stop bit.
                bit_idx <= bit_idx + 4'd1;
                tx      <= data[0];
                data    <= {1'b1, data[7:1]};
            end
        end else begin
            cnt <= cnt + 16'd1;
        end
    end

endmodule

// File: rtl/reg_dump_uart.sv
// rtl/reg_dump_uart.sv - dumps the 32 register-file entries over UART after a header byte
module reg_dump_uart
    import reg_dump_uart_pkg::*;
#(
    parameter int         CLKS_PER_BIT = 868,
    parameter logic [7:0] HDR_BYTE     = HDR_BYTE_DEFAULT
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [31:0] Debug_out,
    output logic [4:0]  Debug_Source_select,
    output logic        tx,
    output logic        busy,
    output logic        done
);
    state_t      state, state_next;
    logic [4:0]  idx;
    logic [31:0] shreg;
    logic [1:0]  byte_cnt;
    logic        latch_phase;
    logic        tx_start;
    logic [7:0]  tx_data;
    logic        tx_busy;
    logic        tx_done;

    uart_tx #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_tx (
        .clk      (clk),
        .reset    (reset),
        .tx_start (tx_start),
        .tx_data  (tx_data),
        .tx       (tx),
        .tx_busy  (tx_busy),
        .tx_done  (tx_done)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state               <= S_IDLE;
            idx                 <= '0;
            Debug_Source_select <= '0;
            shreg               <= '0;
            byte_cnt            <= '0;
            latch_phase         <= 1'b0;
        end else begin
            state <= state_next;
            case (state)
                S_LATCH: begin
                    latch_phase         <= ~latch_phase;
                    Debug_Source_select <= idx;
                    if (latch_phase) begin
                        shreg    <= Debug_out;
                        byte_cnt <= 2'd0;
                    end
                end
                S_BYTE: begin
                    if (tx_done) begin
                        shreg    <= {shreg[23:0], 8'h00};
                        byte_cnt <= byte_cnt + 2'd1;
                    end
                end
                S_NEXT: begin
                    // Select advances here so it is already stable for both LATCH cycles.
                    if (idx != 5'(REG_COUNT - 1)) begin
                        idx                 <= idx + 5'd1;
                        Debug_Source_select <= idx + 5'd1;
                    end
                end
                S_DONE: begin
                    idx                 <= '0;
                    Debug_Source_select <= '0;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        state_next = state;
        tx_start   = 1'b0;
        tx_data    = shreg[31:24];
        done       = 1'b0;
        case (state)
            S_IDLE:  if (start) state_next = S_HDR;
            S_HDR: begin
                tx_start = !tx_busy;
                tx_data  = HDR_BYTE;
                if (tx_done) state_next = S_LATCH;
            end
            S_LATCH: begin
                // Most-significant byte goes straight from the read port on the capture cycle.
                if (latch_phase) begin
                    tx_start   = 1'b1;
                    tx_data    = Debug_out[31:24];
                    state_next = S_BYTE;
                end
            end
            S_BYTE: begin
                tx_start = !tx_busy;
                if (tx_done && byte_cnt == 2'd3) state_next = S_NEXT;
            end
            S_NEXT:  state_next = (idx == 5'(REG_COUNT - 1)) ? S_DONE : S_LATCH;
            S_DONE: begin
                done       = 1'b1;
                state_next = S_IDLE;
            end
            default: state_next = S_IDLE;
        endcase
    end

    assign busy = (state != S_IDLE);

endmodule
